serial_comparator: RTL

//  Bit-serial magnitude comparator: the sequential counterpart of the parallel cascaded comparators.

---
 rtl/serial_comparator_pkg.sv | 28 ++
 rtl/binary_comparator_1bit.sv | 14 +
 rtl/serial_comparator.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_comparator_pkg.sv
// Shared encodings for the serial arithmetic blocks: FSM states and one-hot result bit indices.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int RES_B  = 0;
  localparam int RES_A  = 1;
  localparam int RES_EQ = 2;

  typedef logic [2:0] res_t;

  localparam res_t RES_RESET = res_t'(1) << RES_EQ;

  // Cascade-in normalisation: A>B wins over B>A, anything else counts as equal.
  function automatic res_t seed_res(input logic a_gt, input logic b_gt);
    res_t r;
    r = '0;
    if (a_gt)      r[RES_A]  = 1'b1;
    else if (b_gt) r[RES_B]  = 1'b1;
    else           r[RES_EQ] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/binary_comparator_1bit.sv
// Single-bit magnitude decision used by the serial comparator on the current LSB pair.
module binary_comparator_1bit (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator, LSB first, seeded by a cascade-in result.
// Define SIGNED_CMP_EN for two's-complement operands (MSB step uses inverted sense).
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_bigger1,
  input  logic             a_bigger1,
  input  logic             eq1,
  output logic             busy,
  output logic             done,
  output logic             b_bigger,
  output logic             a_bigger,
  output logic             eq
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sa, sb;
  res_t             work, work_nxt, res_q;
  logic             bit_gt, bit_lt, bit_eq;
  logic             last_step, flip;

  // eq1 carries no information beyond the other two cascade bits under the priority rule.
  logic unused_eq1;
  assign unused_eq1 = eq1;

  binary_comparator_1bit u_bit (
    .a  (sa[0]),
    .b  (sb[0]),
    .gt (bit_gt),
    .lt (bit_lt),
    .eq (bit_eq)
  );

  assign last_step = (count == LAST);

`ifdef SIGNED_CMP_EN
  assign flip = last_step;
`else
  assign flip = 1'b0;
`endif

  always_comb begin
    work_nxt = work;
    if (!bit_eq) begin
      work_nxt         = '0;
      work_nxt[RES_A]  = flip ? bit_lt : bit_gt;
      work_nxt[RES_B]  = flip ? bit_gt : bit_lt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_step) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sa    <= '0;
      sb    <= '0;
      work  <= RES_RESET;
      res_q <= RES_RESET;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          count <= '0;
          work  <= seed_res(a_bigger1, b_bigger1);
        end
        ST_SHIFT: begin
          work  <= work_nxt;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          count <= count + 1'b1;
          // Only the final bit's result becomes architecturally visible.
          if (last_step) res_q <= work_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign a_bigger = res_q[RES_A];
  assign b_bigger = res_q[RES_B];
  assign eq       = res_q[RES_EQ];

endmodule
